instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
- IF pipeline stage; sits directly upstream of the 128x32 instruction memory.
- Owns the 7-bit program counter and drives the memory address. Holds the memory's read-enable high and samples the returned word into the IF/ID pipeline register.
- Handles stall from hazard logic, redirect/flush from branch resolution, and a halt opcode.

Parameters:
- DATA_WIDTH, 32, instruction width.
- ADX_LENGTH, 7, PC / memory address width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPCODE, 6'b111111, instr[31:26] value that halts fetch.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous active-high reset; the instruction memory loads its image while rst is high.
- go  input  1  leaves IDLE and starts fetching.
- stall  input  1  freezes PC and IF/ID.
- redir_valid  input  1  taken branch/jump; flushes IF/ID.
- redir_target  input  ADX_LENGTH  new PC when redir_valid.
- imem_adx  output  ADX_LENGTH  memory address, equal to pc.
- imem_wren  output  1  memory WrEn; constant 1 (read, tri-state driven by memory).
- imem_data  inout  DATA_WIDTH  memory data bus; this block never drives it (always Z).
- ifid_instr  output  DATA_WIDTH  registered instruction.
- ifid_pc  output  ADX_LENGTH  PC of ifid_instr.
- ifid_valid  output  1  ifid_instr is a real instruction.
- halted  output  1  high in HALT state.
- perf_fetch_cnt  output  16  fetched-instruction count (optional feature).
- perf_stall_cnt  output  16  stalled-cycle count (optional feature).

Behaviour:
- Reset (rst=1 at posedge):
  - State=IDLE, pc=RESET_PC.
  - ifid_instr=0, ifid_pc=0, ifid_valid=0, halted=0, both perf counters=0.
  - Reset overrides every other input, including mid-RUN and mid-HALT.
- imem_adx=pc combinationally. Memory read is combinational, so the instruction for pc is captured at the same posedge. Fetch latency is 1 cycle from PC to IF/ID.
- Priority inside RUN: redir_valid > stall > halt detect > normal fetch.
- IDLE:
  - pc held, ifid_valid=0.
  - go=1 -> RUN; the first fetch happens on the next cycle.
  - redir_valid in IDLE: pc<=redir_target, stay IDLE.
- RUN, redirect:
  - pc<=redir_target, ifid_valid<=0, ifid_instr<=0, ifid_pc<=0.
  - Flushes the wrong-path word; stall is ignored that cycle.
- RUN, stall=1:
  - pc, ifid_instr, ifid_pc and ifid_valid all hold.
- RUN, normal fetch:
  - ifid_instr<=imem_data, ifid_pc<=pc, ifid_valid<=1.
  - pc<=pc+1, modulo 2^ADX_LENGTH (127 -> 0 wraps silently).
- RUN, halt detect: imem_data[31:26]==HALT_OPCODE with no stall and no redirect:
  - The halt word is latched into IF/ID with valid=1.
  - pc holds (no increment), state -> HALT.
- HALT:
  - halted=1, pc frozen.
  - stall=1 holds IF/ID; otherwise ifid_valid<=0 and ifid_instr<=0.
  - redir_valid -> pc<=redir_target, IF/ID flushed, state -> RUN, halted<=0.
  - go is ignored.
- Simultaneous go and redir_valid in IDLE: pc<=redir_target and state -> RUN.
- imem_data is treated as unknown outside RUN; it is never sampled in IDLE or HALT.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments on each RUN cycle that loads ifid_valid<=1.
  - perf_stall_cnt increments on each RUN or HALT cycle with stall=1 and no redirect.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: both outputs tied to 0 and no counter registers are built.

Test Plan:
- Reset/idle: rst=1 for 2 cycles then 0, go=0 for 3 cycles -> imem_adx=0, ifid_valid=0, halted=0, ifid_instr=0 throughout.
- Sequential fetch: memory word k = 32'h1000_0000+k, go pulse -> over consecutive cycles ifid_pc=0,1,2,3 with ifid_instr=32'h1000_0000..32'h1000_0003, ifid_valid=1.
- Stall: stall=1 for 3 cycles while ifid_pc=2 -> ifid_pc=2, ifid_instr and imem_adx=3 hold; after release ifid_pc=3 next cycle; with IF_PERF_CNT_EN perf_stall_cnt=3.
- Redirect with stall: redir_valid=1, redir_target=7'd100, stall=1 same cycle -> next cycle ifid_valid=0 and imem_adx=100; the following cycle ifid_pc=100.
- Wrap: redirect to 127 -> ifid_pc=127 then ifid_pc=0, imem_adx sequence 127,0,1.
- Halt: word 5 = 32'hFC00_0000 -> ifid_pc=5 valid=1, halted=1 next cycle, imem_adx stays 5, ifid_valid=0 after; redirect to 0 resumes RUN, and rst mid-HALT returns to IDLE with pc=0.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, reads the combinational instruction memory and fills the IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module instr_fetch_stage #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADX_LENGTH  = 7,
  parameter logic [ADX_LENGTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]            HALT_OPCODE = 6'b111111
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  stall,
  input  logic                  redir_valid,
  input  logic [ADX_LENGTH-1:0] redir_target,
  output logic [ADX_LENGTH-1:0] imem_adx,
  output logic                  imem_wren,
  inout  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] ifid_instr,
  output logic [ADX_LENGTH-1:0] ifid_pc,
  output logic                  ifid_valid,
  output logic                  halted,
  output logic [15:0]           perf_fetch_cnt,
  output logic [15:0]           perf_stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [ADX_LENGTH-1:0] PC_ONE = {{(ADX_LENGTH-1){1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic [ADX_LENGTH-1:0]   pc, pc_nxt;
  logic [DATA_WIDTH-1:0]   instr_nxt;
  logic [ADX_LENGTH-1:0]   ipc_nxt;
  logic                    vld_nxt;
  logic                    is_halt_op;

  // The memory owns the data bus; a read is requested by holding WrEn high.
  assign imem_data  = 'z;
  assign imem_wren  = 1'b1;
  assign imem_adx   = pc;
  assign halted     = (state == S_HALT);
  assign is_halt_op = (imem_data[DATA_WIDTH-1 -: 6] == HALT_OPCODE);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = ifid_instr;
    ipc_nxt   = ifid_pc;
    vld_nxt   = ifid_valid;
    unique case (state)
      S_IDLE: begin
        vld_nxt = 1'b0;
        if (redir_valid) pc_nxt = redir_target;
        if (go) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (redir_valid) begin
          pc_nxt    = redir_target;
          instr_nxt = '0;
          ipc_nxt   = '0;
          vld_nxt   = 1'b0;
        end else if (!stall) begin
          instr_nxt = imem_data;
          ipc_nxt   = pc;
          vld_nxt   = 1'b1;
          // A halt word is delivered downstream but the PC parks on it.
          if (is_halt_op) state_nxt = S_HALT;
          else            pc_nxt    = pc + PC_ONE;
        end
      end
      S_HALT: begin
        if (redir_valid) begin
          pc_nxt    = redir_target;
          instr_nxt = '0;
          ipc_nxt   = '0;
          vld_nxt   = 1'b0;
          state_nxt = S_RUN;
        end else if (!stall) begin
          instr_nxt = '0;
          vld_nxt   = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC / IF-ID register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ifid_instr <= instr_nxt;
      ifid_pc    <= ipc_nxt;
      ifid_valid <= vld_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt, stall_cnt;
  logic        fetch_evt, stall_evt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign fetch_evt = (state == S_RUN) && !redir_valid && !stall;
  assign stall_evt = ((state == S_RUN) || (state == S_HALT)) && stall && !redir_valid;

  // Counter register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_evt) fetch_cnt <= sat_inc(fetch_cnt);
      if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural fetch model.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, go, stall, redir_valid;
  logic [6:0]  redir_target;
  logic [6:0]  imem_adx;
  logic        imem_wren;
  wire  [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [6:0]  ifid_pc;
  logic        ifid_valid, halted;
  logic [15:0] perf_fetch_cnt, perf_stall_cnt;

  logic [31:0] mem [128];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // behavioural model: 0=idle 1=run 2=halt
  int          m_mode  = 0;
  int          m_pc    = 0;
  logic [31:0] m_instr = '0;
  int          m_ipc   = 0;
  bit          m_valid = 1'b0;
  int          m_fcnt  = 0;
  int          m_scnt  = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_wren ? mem[imem_adx] : 'z;

  instr_fetch_stage dut (
    .clk(clk), .rst(rst), .go(go), .stall(stall),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .imem_adx(imem_adx), .imem_wren(imem_wren), .imem_data(imem_data),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .halted(halted), .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_instr = '0; m_ipc = 0; m_valid = 0; m_fcnt = 0; m_scnt = 0;
    end else if (m_mode == 0) begin
      m_valid = 0;
      if (redir_valid) m_pc = redir_target;
      if (go) m_mode = 1;
    end else if (redir_valid) begin
      m_pc = redir_target; m_instr = '0; m_ipc = 0; m_valid = 0; m_mode = 1;
    end else if (stall) begin
      m_scnt++;
    end else if (m_mode == 2) begin
      m_instr = '0; m_valid = 0;
    end else begin
      w = mem[m_pc];
      m_instr = w; m_ipc = m_pc; m_valid = 1; m_fcnt++;
      if (w[31:26] == 6'b111111) m_mode = 2;
      else m_pc = (m_pc + 1) % 128;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_adx",   32'(imem_adx),   32'(m_pc));
      chk("model_wren",  32'(imem_wren),  32'd1);
      chk("model_valid", 32'(ifid_valid), 32'(m_valid));
      chk("model_halt",  32'(halted),     32'(m_mode == 2));
      chk("model_instr", ifid_instr,      m_instr);
      chk("model_ipc",   32'(ifid_pc),    32'(m_ipc));
`ifdef IF_PERF_CNT_EN
      chk("model_fcnt",  32'(perf_fetch_cnt), 32'(sat16(m_fcnt)));
      chk("model_scnt",  32'(perf_stall_cnt), 32'(sat16(m_scnt)));
`else
      chk("perf_fcnt_off", 32'(perf_fetch_cnt), 32'd0);
      chk("perf_scnt_off", 32'(perf_stall_cnt), 32'd0);
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = 32'h1000_0000 + k;
    rst = 1; go = 0; stall = 0; redir_valid = 0; redir_target = '0;
    tick(2);
    chk_en = 1'b1;
    rst = 0;

    // reset / idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_adx",   32'(imem_adx),   32'd0);
      chk("idle_valid", 32'(ifid_valid), 32'd0);
      chk("idle_halt",  32'(halted),     32'd0);
      chk("idle_instr", ifid_instr,      32'd0);
    end

    // sequential fetch
    go = 1; tick(); go = 0;
    chk("first_adx", 32'(imem_adx), 32'd0);
    chk("first_vld", 32'(ifid_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_pc",    32'(ifid_pc),    32'(i));
      chk("seq_instr", ifid_instr,      32'h1000_0000 + i);
      chk("seq_valid", 32'(ifid_valid), 32'd1);
    end

    // stall while ifid_pc=2
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc",    32'(ifid_pc),  32'd2);
      chk("stall_instr", ifid_instr,    32'h1000_0002);
      chk("stall_adx",   32'(imem_adx), 32'd3);
    end
    stall = 0; tick();
    chk("unstall_pc", 32'(ifid_pc), 32'd3);
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt", 32'(perf_stall_cnt), 32'd3);
`endif

    // redirect beats stall
    redir_valid = 1; redir_target = 7'd100; stall = 1; tick();
    redir_valid = 0; stall = 0;
    chk("redir_valid", 32'(ifid_valid), 32'd0);
    chk("redir_adx",   32'(imem_adx),   32'd100);
    tick();
    chk("redir_pc",    32'(ifid_pc),    32'd100);
    chk("redir_instr", ifid_instr,      32'h1000_0064);

    // wrap
    redir_valid = 1; redir_target = 7'd127; tick(); redir_valid = 0;
    chk("wrap_adx0", 32'(imem_adx), 32'd127);
    tick();
    chk("wrap_pc127", 32'(ifid_pc), 32'd127);
    chk("wrap_adx1",  32'(imem_adx), 32'd0);
    tick();
    chk("wrap_pc0",  32'(ifid_pc), 32'd0);
    chk("wrap_adx2", 32'(imem_adx), 32'd1);

    // halt at word 5
    mem[5] = 32'hFC00_0000;
    tick(4);
    chk("pre_halt_adx", 32'(imem_adx), 32'd5);
    tick();
    chk("halt_pc",    32'(ifid_pc),    32'd5);
    chk("halt_valid", 32'(ifid_valid), 32'd1);
    chk("halt_instr", ifid_instr,      32'hFC00_0000);
    chk("halt_flag",  32'(halted),     32'd1);
    tick(2);
    chk("halt_adx",    32'(imem_adx),   32'd5);
    chk("halt_vld0",   32'(ifid_valid), 32'd0);
    chk("halt_held",   32'(halted),     32'd1);
    go = 1; tick(); go = 0;
    chk("halt_go_ign", 32'(halted), 32'd1);
    redir_valid = 1; redir_target = 7'd0; tick(); redir_valid = 0;
    chk("resume_halt", 32'(halted),   32'd0);
    chk("resume_adx",  32'(imem_adx), 32'd0);
    tick();
    chk("resume_pc",   32'(ifid_pc),  32'd0);
    redir_valid = 1; redir_target = 7'd5; tick(); redir_valid = 0;
    tick(2);
    chk("rehalt", 32'(halted), 32'd1);
    rst = 1; tick(); rst = 0;
    chk("rst_halt",  32'(halted),     32'd0);
    chk("rst_adx",   32'(imem_adx),   32'd0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_instr", ifid_instr,      32'd0);
    tick();
    chk("rst_idle_adx", 32'(imem_adx), 32'd0);

    // randomized traffic
    for (int k = 0; k < 128; k++) begin
      mem[k] = $urandom;
      if ($urandom_range(7) == 0) mem[k][31:26] = 6'b111111;
      else if (mem[k][31:26] == 6'b111111) mem[k][26] = 1'b0;
    end
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(199) == 0);
      go           = ($urandom_range(3) == 0);
      stall        = ($urandom_range(3) == 0);
      redir_valid  = ($urandom_range(9) == 0);
      redir_target = 7'($urandom);
      if ($urandom_range(15) == 0) mem[$urandom_range(127)] = $urandom;
      tick();
    end
    rst = 0; go = 0; stall = 0; redir_valid = 0;
    tick();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
